// File: rtl/riscv_defines.sv
// Shared core definitions: DIFT instruction classes, TPR propagation modes
// (reusing the ALU_MODE_* encodings) and the tag-unit trap FSM states.
package riscv_defines;

    localparam int unsigned DIFT_NUM_CLASSES = 7;

    localparam logic [2:0] DIFT_CLASS_INTEGER    = 3'd0;
    localparam logic [2:0] DIFT_CLASS_BRANCH     = 3'd1;
    localparam logic [2:0] DIFT_CLASS_JUMP       = 3'd2;
    localparam logic [2:0] DIFT_CLASS_SHIFT      = 3'd3;
    localparam logic [2:0] DIFT_CLASS_COMPARISON = 3'd4;
    localparam logic [2:0] DIFT_CLASS_LOGICAL    = 3'd5;
    localparam logic [2:0] DIFT_CLASS_LOADSTORE  = 3'd6;
    localparam logic [2:0] DIFT_CLASS_NONE       = 3'd7;

    // Existing ALU mode encodings, reused as TPR propagation modes
    localparam logic [1:0] ALU_MODE_OLD   = 2'b00;
    localparam logic [1:0] ALU_MODE_AND   = 2'b01;
    localparam logic [1:0] ALU_MODE_OR    = 2'b10;
    localparam logic [1:0] ALU_MODE_CLEAR = 2'b11;

    typedef enum logic [1:0] {TAG_IDLE, TAG_TRAP, TAG_ACK} dift_tag_state_e;

endpackage

// File: rtl/riscv_dift_tag_policy.sv
// Combinational DIFT policy slice: selects the TPR mode and TCR check bits for
// the instruction class, then produces the result tag and the violation flags.
// Classes at or above NUM_CLASSES (i.e. DIFT_CLASS_NONE) clear and never check.
module riscv_dift_tag_policy
    import riscv_defines::*;
#(
    parameter int unsigned TAG_WIDTH   = 1,
    parameter int unsigned NUM_CLASSES = DIFT_NUM_CLASSES
) (
    input  logic [2:0]               insn_class_i,
    input  logic [TAG_WIDTH-1:0]     tag_a_i,
    input  logic [TAG_WIDTH-1:0]     tag_b_i,
    input  logic [TAG_WIDTH-1:0]     tag_rd_old_i,
    input  logic [2*NUM_CLASSES-1:0] tpr_i,
    input  logic [2*NUM_CLASSES-1:0] tcr_i,
    output logic [TAG_WIDTH-1:0]     res_tag_o,
    output logic                     viol_a_o,
    output logic                     viol_b_o
);

    logic [1:0] mode;
    logic [1:0] chk;

    // Slice TPR/TCR by class and apply the propagation rule
    always_comb begin
        mode = ALU_MODE_CLEAR;
        chk  = 2'b00;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (insn_class_i == 3'(k)) begin
                mode = tpr_i[2*k +: 2];
                chk  = tcr_i[2*k +: 2];
            end
        end
        unique case (mode)
            ALU_MODE_OLD: res_tag_o = tag_rd_old_i;
            ALU_MODE_AND: res_tag_o = tag_a_i & tag_b_i;
            ALU_MODE_OR:  res_tag_o = tag_a_i | tag_b_i;
            default:      res_tag_o = '0;
        endcase
        viol_a_o = chk[0] & (|tag_a_i);
        viol_b_o = chk[1] & (|tag_b_i);
    end

endmodule

// File: rtl/riscv_dift_tag_unit.sv
// ID->EX DIFT tag stage: pipeline register for the destination tag, trap FSM
// (IDLE -> TRAP -> ACK -> IDLE) and an optional saturating violation counter,
// enabled with the DIFT_VIOL_COUNTER_EN macro.
module riscv_dift_tag_unit
    import riscv_defines::*;
#(
    parameter int unsigned TAG_WIDTH   = 1,
    parameter int unsigned NUM_CLASSES = DIFT_NUM_CLASSES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid_i,
    input  logic                     ex_ready_i,
    input  logic                     flush_i,
    input  logic [2:0]               insn_class_i,
    input  logic [31:0]              pc_i,
    input  logic [TAG_WIDTH-1:0]     tag_a_i,
    input  logic [TAG_WIDTH-1:0]     tag_b_i,
    input  logic [TAG_WIDTH-1:0]     tag_rd_old_i,
    input  logic [2*NUM_CLASSES-1:0] tpr_i,
    input  logic [2*NUM_CLASSES-1:0] tcr_i,
    input  logic                     trap_ack_i,
    output logic                     ex_tag_valid_o,
    output logic [TAG_WIDTH-1:0]     ex_tag_rd_o,
    output logic                     halt_id_o,
    output logic                     tag_trap_o,
    output logic [31:0]              trap_pc_o,
    output logic [4:0]               trap_cause_o,
    output logic [31:0]              viol_cnt_o
);

    dift_tag_state_e        state_q;
    logic                   ex_tag_valid_q;
    logic [TAG_WIDTH-1:0]   ex_tag_rd_q;
    logic                   tag_trap_q;
    logic                   halt_id_q;
    logic [31:0]            trap_pc_q;
    logic [4:0]             trap_cause_q;

    logic [TAG_WIDTH-1:0]   res_tag;
    logic                   viol_a;
    logic                   viol_b;
    logic                   viol;
    logic                   accept;
    logic                   trap_entry;

    riscv_dift_tag_policy #(
        .TAG_WIDTH   (TAG_WIDTH),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_policy (
        .insn_class_i (insn_class_i),
        .tag_a_i      (tag_a_i),
        .tag_b_i      (tag_b_i),
        .tag_rd_old_i (tag_rd_old_i),
        .tpr_i        (tpr_i),
        .tcr_i        (tcr_i),
        .res_tag_o    (res_tag),
        .viol_a_o     (viol_a),
        .viol_b_o     (viol_b)
    );

    assign viol       = viol_a | viol_b;
    assign accept     = id_valid_i & ex_ready_i & (state_q == TAG_IDLE);
    assign trap_entry = accept & viol;

    // ID->EX tag register: holds on stall, violating instructions are suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag_valid_q <= 1'b0;
            ex_tag_rd_q    <= '0;
        end else if (flush_i) begin
            ex_tag_valid_q <= 1'b0;
        end else if (ex_ready_i) begin
            ex_tag_valid_q <= accept & ~viol;
            if (accept && !viol) begin
                ex_tag_rd_q <= res_tag;
            end
        end
    end

    // Trap FSM with registered trap/halt outputs; flush never clears a pending trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TAG_IDLE;
            tag_trap_q   <= 1'b0;
            halt_id_q    <= 1'b0;
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
        end else begin
            case (state_q)
                TAG_IDLE: begin
                    if (trap_entry) begin
                        state_q      <= TAG_TRAP;
                        tag_trap_q   <= 1'b1;
                        halt_id_q    <= 1'b1;
                        trap_pc_q    <= pc_i;
                        trap_cause_q <= {insn_class_i, viol_b, viol_a};
                    end
                end
                TAG_TRAP: begin
                    if (trap_ack_i) begin
                        state_q    <= TAG_ACK;
                        tag_trap_q <= 1'b0;
                    end
                end
                TAG_ACK: begin
                    state_q   <= TAG_IDLE;
                    halt_id_q <= 1'b0;
                end
                default: begin
                    state_q    <= TAG_IDLE;
                    tag_trap_q <= 1'b0;
                    halt_id_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIFT_VIOL_COUNTER_EN
    logic [31:0] viol_cnt_q;

    // Saturating count of trap entries, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt_q <= '0;
        end else if (trap_entry && (viol_cnt_q != 32'hFFFF_FFFF)) begin
            viol_cnt_q <= viol_cnt_q + 32'd1;
        end
    end

    assign viol_cnt_o = viol_cnt_q;
`else
    assign viol_cnt_o = '0;
`endif

    assign ex_tag_valid_o = ex_tag_valid_q;
    assign ex_tag_rd_o    = ex_tag_rd_q;
    assign halt_id_o      = halt_id_q;
    assign tag_trap_o     = tag_trap_q;
    assign trap_pc_o      = trap_pc_q;
    assign trap_cause_o   = trap_cause_q;

endmodule

// File: tb/tb_riscv_dift_tag_unit.sv
// Self-checking bench for riscv_dift_tag_unit: directed scenarios plus a
// randomized run against a cycle-level reference model of the tag stage.
module tb_riscv_dift_tag_unit;
    import riscv_defines::*;

    localparam int TW = 1;
    localparam int NC = 7;

    logic            clk;
    logic            rst_n;
    logic            id_valid_i;
    logic            ex_ready_i;
    logic            flush_i;
    logic [2:0]      insn_class_i;
    logic [31:0]     pc_i;
    logic [TW-1:0]   tag_a_i;
    logic [TW-1:0]   tag_b_i;
    logic [TW-1:0]   tag_rd_old_i;
    logic [2*NC-1:0] tpr_i;
    logic [2*NC-1:0] tcr_i;
    logic            trap_ack_i;
    logic            ex_tag_valid_o;
    logic [TW-1:0]   ex_tag_rd_o;
    logic            halt_id_o;
    logic            tag_trap_o;
    logic [31:0]     trap_pc_o;
    logic [4:0]      trap_cause_o;
    logic [31:0]     viol_cnt_o;

    int checks = 0;
    int errors = 0;

    riscv_dift_tag_unit #(
        .TAG_WIDTH   (TW),
        .NUM_CLASSES (NC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .ex_ready_i     (ex_ready_i),
        .flush_i        (flush_i),
        .insn_class_i   (insn_class_i),
        .pc_i           (pc_i),
        .tag_a_i        (tag_a_i),
        .tag_b_i        (tag_b_i),
        .tag_rd_old_i   (tag_rd_old_i),
        .tpr_i          (tpr_i),
        .tcr_i          (tcr_i),
        .trap_ack_i     (trap_ack_i),
        .ex_tag_valid_o (ex_tag_valid_o),
        .ex_tag_rd_o    (ex_tag_rd_o),
        .halt_id_o      (halt_id_o),
        .tag_trap_o     (tag_trap_o),
        .trap_pc_o      (trap_pc_o),
        .trap_cause_o   (trap_cause_o),
        .viol_cnt_o     (viol_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid_i   = 1'b0;
        ex_ready_i   = 1'b1;
        flush_i      = 1'b0;
        insn_class_i = 3'd0;
        pc_i         = 32'h0;
        tag_a_i      = '0;
        tag_b_i      = '0;
        tag_rd_old_i = '0;
        tpr_i        = '0;
        tcr_i        = '0;
        trap_ack_i   = 1'b0;
    endtask

    // Reference: destination tag from class, tags and TPR
    function automatic logic [TW-1:0] ref_tag(input int cls, input logic [TW-1:0] a,
                                              input logic [TW-1:0] b, input logic [TW-1:0] old,
                                              input logic [2*NC-1:0] tpr);
        int mode;
        if (cls >= NC) return '0;
        mode = int'((tpr >> (2 * cls)) & 14'd3);
        if (mode == int'(ALU_MODE_OLD)) return old;
        if (mode == int'(ALU_MODE_AND)) return a & b;
        if (mode == int'(ALU_MODE_OR)) return a | b;
        return '0;
    endfunction

    // Reference: operand check (which=0 -> A, which=1 -> B)
    function automatic logic ref_viol(input int cls, input logic [TW-1:0] t,
                                      input logic [2*NC-1:0] tcr, input int which);
        if (cls >= NC) return 1'b0;
        return ((tcr >> (2 * cls + which)) & 14'd1) != 0 && t != 0;
    endfunction

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_tag_valid_o); end
        checks++; if (ex_tag_rd_o !== '0) begin errors++; $display("FAIL reset_tag got %h want 0", ex_tag_rd_o); end
        checks++; if (tag_trap_o !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", tag_trap_o); end
        checks++; if (halt_id_o !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", halt_id_o); end
        checks++; if (trap_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", trap_pc_o); end
        checks++; if (trap_cause_o !== 5'h0) begin errors++; $display("FAIL reset_cause got %h want 0", trap_cause_o); end
        checks++; if (viol_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", viol_cnt_o); end
        rst_n = 1'b1;
        tick();
    endtask

    // Propagation modes on the INTEGER class: {mode, a, b, old, expected}
    task automatic test_propagate();
        logic [1:0]  modes [4] = '{ALU_MODE_OR, ALU_MODE_AND, ALU_MODE_OLD, ALU_MODE_CLEAR};
        logic [3:0]  vecs  [4] = '{4'b1001, 4'b1000, 4'b0011, 4'b1110};
        logic [3:0]  v;
        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            set_idle();
            tpr_i[1:0]   = modes[i];
            insn_class_i = DIFT_CLASS_INTEGER;
            tag_a_i      = v[3];
            tag_b_i      = v[2];
            tag_rd_old_i = v[1];
            id_valid_i   = 1'b1;
            tick();
            id_valid_i = 1'b0;
            checks++; if (ex_tag_valid_o !== 1'b1) begin errors++; $display("FAIL prop_valid[%0d] got %b want 1", i, ex_tag_valid_o); end
            checks++; if (ex_tag_rd_o !== v[0]) begin errors++; $display("FAIL prop_tag[%0d] got %b want %b", i, ex_tag_rd_o, v[0]); end
        end
        tick();
    endtask

    task automatic test_branch_trap();
        set_idle();
        tcr_i        = 14'b00_0000_0000_0100;
        insn_class_i = DIFT_CLASS_BRANCH;
        tag_a_i      = 1'b1;
        pc_i         = 32'h0000_1000;
        id_valid_i   = 1'b1;
        tick();
        set_idle();
        checks++; if (tag_trap_o !== 1'b1) begin errors++; $display("FAIL trap_req got %b want 1", tag_trap_o); end
        checks++; if (trap_pc_o !== 32'h1000) begin errors++; $display("FAIL trap_pc got %h want 1000", trap_pc_o); end
        checks++; if (trap_cause_o !== 5'b00101) begin errors++; $display("FAIL trap_cause got %b want 00101", trap_cause_o); end
        checks++; if (halt_id_o !== 1'b1) begin errors++; $display("FAIL trap_halt got %b want 1", halt_id_o); end
        checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL trap_suppress got %b want 0", ex_tag_valid_o); end
    endtask

    // Continues from the pending trap left by test_branch_trap
    task automatic test_ack_hold();
        set_idle();
        tpr_i[1:0] = ALU_MODE_OR;
        tag_a_i    = 1'b1;
        id_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (tag_trap_o !== 1'b1) begin errors++; $display("FAIL hold_trap[%0d] got %b want 1", i, tag_trap_o); end
            checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL hold_noaccept[%0d] got %b want 0", i, ex_tag_valid_o); end
        end
        trap_ack_i = 1'b1;
        tick();
        trap_ack_i = 1'b0;
        checks++; if (tag_trap_o !== 1'b0) begin errors++; $display("FAIL ack_trap got %b want 0", tag_trap_o); end
        checks++; if (halt_id_o !== 1'b1) begin errors++; $display("FAIL ack_halt got %b want 1", halt_id_o); end
        checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL ack_noaccept got %b want 0", ex_tag_valid_o); end
        tick();
        checks++; if (halt_id_o !== 1'b0) begin errors++; $display("FAIL idle_halt got %b want 0", halt_id_o); end
        checks++; if (trap_pc_o !== 32'h1000) begin errors++; $display("FAIL pc_hold got %h want 1000", trap_pc_o); end
        tick();
        checks++; if (ex_tag_valid_o !== 1'b1) begin errors++; $display("FAIL reaccept_valid got %b want 1", ex_tag_valid_o); end
        checks++; if (ex_tag_rd_o !== 1'b1) begin errors++; $display("FAIL reaccept_tag got %b want 1", ex_tag_rd_o); end
        set_idle();
        tick();
    endtask

    task automatic test_stall_flush();
        set_idle();
        tpr_i[1:0] = ALU_MODE_OR;
        tag_a_i    = 1'b1;
        id_valid_i = 1'b1;
        tick();
        tag_a_i    = 1'b0;
        ex_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ex_tag_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, ex_tag_valid_o); end
            checks++; if (ex_tag_rd_o !== 1'b1) begin errors++; $display("FAIL stall_tag[%0d] got %b want 1", i, ex_tag_rd_o); end
        end
        flush_i = 1'b1;
        tick();
        set_idle();
        checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", ex_tag_valid_o); end
        tick();
    endtask

    task automatic test_class_none_reset();
        set_idle();
        insn_class_i = DIFT_CLASS_NONE;
        tag_a_i      = 1'b1;
        tag_b_i      = 1'b1;
        tag_rd_old_i = 1'b1;
        tcr_i        = '1;
        id_valid_i   = 1'b1;
        tick();
        set_idle();
        checks++; if (ex_tag_rd_o !== 1'b0) begin errors++; $display("FAIL none_tag got %b want 0", ex_tag_rd_o); end
        checks++; if (ex_tag_valid_o !== 1'b1) begin errors++; $display("FAIL none_valid got %b want 1", ex_tag_valid_o); end
        checks++; if (tag_trap_o !== 1'b0) begin errors++; $display("FAIL none_trap got %b want 0", tag_trap_o); end
        // Enter TRAP, then reset asynchronously mid-cycle
        tcr_i      = 14'b1;
        tag_a_i    = 1'b1;
        pc_i       = 32'hDEAD_BEE0;
        id_valid_i = 1'b1;
        tick();
        set_idle();
        checks++; if (tag_trap_o !== 1'b1) begin errors++; $display("FAIL pre_rst_trap got %b want 1", tag_trap_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tag_trap_o !== 1'b0) begin errors++; $display("FAIL arst_trap got %b want 0", tag_trap_o); end
        checks++; if (halt_id_o !== 1'b0) begin errors++; $display("FAIL arst_halt got %b want 0", halt_id_o); end
        checks++; if (trap_pc_o !== 32'h0) begin errors++; $display("FAIL arst_pc got %h want 0", trap_pc_o); end
        checks++; if (trap_cause_o !== 5'h0) begin errors++; $display("FAIL arst_cause got %h want 0", trap_cause_o); end
        checks++; if (ex_tag_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", ex_tag_valid_o); end
        checks++; if (viol_cnt_o !== 32'h0) begin errors++; $display("FAIL arst_cnt got %h want 0", viol_cnt_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_counter();
        logic [31:0] want;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            tcr_i      = 14'b1;
            tag_a_i    = 1'b1;
            id_valid_i = 1'b1;
            tick();
            set_idle();
            trap_ack_i = 1'b1;
            tick();
            trap_ack_i = 1'b0;
            tick();
        end
`ifdef DIFT_VIOL_COUNTER_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        checks++; if (viol_cnt_o !== want) begin errors++; $display("FAIL cnt_three got %h want %h", viol_cnt_o, want); end
`ifdef DIFT_VIOL_COUNTER_EN
        force dut.viol_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.viol_cnt_q;
        want = 32'hFFFF_FFFF;
`endif
        set_idle();
        tcr_i      = 14'b1;
        tag_a_i    = 1'b1;
        id_valid_i = 1'b1;
        tick();
        set_idle();
        checks++; if (viol_cnt_o !== want) begin errors++; $display("FAIL cnt_sat got %h want %h", viol_cnt_o, want); end
        trap_ack_i = 1'b1;
        tick();
        trap_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic          m_valid;
        logic [TW-1:0] m_tag;
        int            m_phase;  // 0 idle, 1 trap pending, 2 ack cycle
        logic [31:0]   m_pc;
        logic [4:0]    m_cause;
        logic [31:0]   m_cnt;
        logic          acc, va, vb;
        logic [TW-1:0] rt;
        int            cls;

        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m_valid = 1'b0; m_tag = '0; m_phase = 0; m_pc = '0; m_cause = '0; m_cnt = '0;

        for (int n = 0; n < 500; n++) begin
            id_valid_i   = ($urandom_range(0, 3) != 0);
            ex_ready_i   = ($urandom_range(0, 4) != 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            insn_class_i = 3'($urandom_range(0, 7));
            pc_i         = $urandom();
            tag_a_i      = TW'($urandom_range(0, 1));
            tag_b_i      = TW'($urandom_range(0, 1));
            tag_rd_old_i = TW'($urandom_range(0, 1));
            tpr_i        = 14'($urandom());
            tcr_i        = ($urandom_range(0, 2) == 0) ? 14'($urandom()) : 14'h0;
            trap_ack_i   = ($urandom_range(0, 2) == 0);

            cls = int'(insn_class_i);
            acc = id_valid_i && ex_ready_i && (m_phase == 0);
            rt  = ref_tag(cls, tag_a_i, tag_b_i, tag_rd_old_i, tpr_i);
            va  = ref_viol(cls, tag_a_i, tcr_i, 0);
            vb  = ref_viol(cls, tag_b_i, tcr_i, 1);

            if (flush_i) begin
                m_valid = 1'b0;
            end else if (ex_ready_i) begin
                m_valid = acc && !(va || vb);
                if (acc && !(va || vb)) m_tag = rt;
            end
            if (m_phase == 0) begin
                if (acc && (va || vb)) begin
                    m_phase = 1;
                    m_pc    = pc_i;
                    m_cause = {insn_class_i, vb, va};
`ifdef DIFT_VIOL_COUNTER_EN
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
                end
            end else if (m_phase == 1) begin
                if (trap_ack_i) m_phase = 2;
            end else begin
                m_phase = 0;
            end

            tick();
            checks++; if (ex_tag_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, ex_tag_valid_o, m_valid); end
            checks++; if (ex_tag_rd_o !== m_tag) begin errors++; $display("FAIL rnd_tag[%0d] got %b want %b", n, ex_tag_rd_o, m_tag); end
            checks++; if (tag_trap_o !== (m_phase == 1)) begin errors++; $display("FAIL rnd_trap[%0d] got %b want %b", n, tag_trap_o, (m_phase == 1)); end
            checks++; if (halt_id_o !== (m_phase != 0)) begin errors++; $display("FAIL rnd_halt[%0d] got %b want %b", n, halt_id_o, (m_phase != 0)); end
            checks++; if (trap_pc_o !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", n, trap_pc_o, m_pc); end
            checks++; if (trap_cause_o !== m_cause) begin errors++; $display("FAIL rnd_cause[%0d] got %b want %b", n, trap_cause_o, m_cause); end
            checks++; if (viol_cnt_o !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %h want %h", n, viol_cnt_o, m_cnt); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        test_reset();
        test_propagate();
        test_branch_trap();
        test_ack_hold();
        test_stall_flush();
        test_class_none_reset();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
